// File: rtl/jtpopeye_prog_pkg.sv
// Shared constants and the FIFO word layout for the ROM-download programming sink.
package jtpopeye_prog_pkg;

    localparam int PROG_AW = 22;
    localparam int PROG_DW = 16;

    // Lane enables are active-low: bit1 gates [15:8], bit0 gates [7:0].
    localparam logic [1:0] MASK_NONE = 2'b11;
    localparam logic [1:0] MASK_HI   = 2'b01;
    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_BOTH = 2'b00;

    typedef struct packed {
        logic [PROG_AW-1:0] addr;
        logic [PROG_DW-1:0] data;
        logic [1:0]         mask;
    } prog_word_t;

    localparam int PROG_WORD_W = $bits(prog_word_t);

    function automatic logic [PROG_DW-1:0] place_byte(input logic [7:0] din8,
                                                      input logic [1:0] mask,
                                                      input logic [PROG_DW-1:0] base);
        logic [PROG_DW-1:0] word;
        word = base;
        if ((mask | MASK_HI) == MASK_HI) word[15:8] = din8;
        if ((mask | MASK_LO) == MASK_LO) word[7:0]  = din8;
        return word;
    endfunction

endpackage

// File: rtl/jtpopeye_prog_fifo.sv
// Small synchronous FIFO for merged SDRAM words; exposes the head and the entry behind it.
module jtpopeye_prog_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [W-1:0] second,
    output logic         full,
    output logic         empty,
    output logic         multi
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  rd_next;
    logic [AW:0]  level;
    logic         do_push;
    logic         do_pop;

    assign rd_next = rd_ptr + 1'b1;
    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign multi   = (level > (AW+1)'(1));
    assign head    = mem[rd_ptr[AW-1:0]];
    assign second  = mem[rd_next[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_next;
        end
    end

endmodule

// File: rtl/jtpopeye_prog_sink.sv
// Merges byte-lane download writes into 16-bit words, queues them and feeds them
// to the SDRAM with a req/ack handshake.
module jtpopeye_prog_sink
    import jtpopeye_prog_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int HOLD_CYC = 15
) (
    input  logic               clk_rom,
    input  logic               rst,
    input  logic               downloading,
    input  logic               prog_we,
    input  logic [PROG_AW-1:0] prog_addr,
    input  logic [7:0]         prog_data,
    input  logic [1:0]         prog_mask,
    output logic               sdram_req,
    output logic [PROG_AW-1:0] sdram_addr,
    output logic [PROG_DW-1:0] sdram_din,
    output logic [1:0]         sdram_mask,
    input  logic               sdram_ack,
    output logic               done,
    output logic               overflow
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC - 1);

    prog_word_t         hold;
    prog_word_t         push_word;
    prog_word_t         fifo_head;
    prog_word_t         fifo_second;
    logic               hold_valid;
    logic [3:0]         hold_cnt;
    logic               dl_d;
    logic               accept;
    logic               merge_ok;
    logic               fall;
    logic               timeout;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_multi;
    logic [1:0]         merged_mask;
    logic [PROG_DW-1:0] merged_data;

    assign accept      = prog_we && (prog_mask != MASK_NONE);
    assign merge_ok    = hold_valid && (hold.addr == prog_addr) &&
                         ((hold.mask | prog_mask) == MASK_NONE);
    assign merged_mask = hold.mask & prog_mask;
    assign merged_data = place_byte(prog_data, prog_mask, hold.data);
    assign fall        = dl_d && !downloading;
    assign timeout     = (hold_cnt == HOLD_LAST);
    assign pop         = sdram_req && sdram_ack;

    // A write takes priority over the timeout and end-of-download flushes.
    always_comb begin
        push      = 1'b0;
        push_word = hold;
        if (accept) begin
            if (merge_ok) begin
                if (merged_mask == MASK_BOTH) begin
                    push      = 1'b1;
                    push_word = '{addr: hold.addr, data: merged_data, mask: merged_mask};
                end
            end else if (hold_valid) begin
                push = 1'b1;
            end
        end else if (hold_valid && (fall || timeout)) begin
            push = 1'b1;
        end
    end

    always_ff @(posedge clk_rom or posedge rst) begin
        if (rst) begin
            hold       <= '{addr: '0, data: '0, mask: MASK_NONE};
            hold_valid <= 1'b0;
            hold_cnt   <= '0;
            dl_d       <= 1'b0;
        end else begin
            dl_d <= downloading;
            if (accept) begin
                hold_cnt <= '0;
                if (merge_ok) begin
                    hold.data  <= merged_data;
                    hold.mask  <= merged_mask;
                    hold_valid <= (merged_mask != MASK_BOTH);
                end else begin
                    hold       <= '{addr: prog_addr, data: {prog_data, prog_data}, mask: prog_mask};
                    hold_valid <= 1'b1;
                end
            end else if (hold_valid) begin
                if (fall || timeout) begin
                    hold_valid <= 1'b0;
                    hold_cnt   <= '0;
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end

    jtpopeye_prog_fifo #(
        .DEPTH (DEPTH),
        .W     (PROG_WORD_W)
    ) u_fifo (
        .clk    (clk_rom),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .din    (push_word),
        .head   (fifo_head),
        .second (fifo_second),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .multi  (fifo_multi)
    );

    // The head stays in the FIFO while presented; on ack the entry behind it follows.
    always_ff @(posedge clk_rom or posedge rst) begin
        if (rst) begin
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            sdram_din  <= '0;
            sdram_mask <= MASK_NONE;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (!sdram_req) begin
                if (!fifo_empty) begin
                    sdram_req  <= 1'b1;
                    sdram_addr <= fifo_head.addr;
                    sdram_din  <= fifo_head.data;
                    sdram_mask <= fifo_head.mask;
                end
            end else if (sdram_ack) begin
                if (fifo_multi) begin
                    sdram_addr <= fifo_second.addr;
                    sdram_din  <= fifo_second.data;
                    sdram_mask <= fifo_second.mask;
                end else begin
                    sdram_req <= 1'b0;
                end
            end
            if (push && fifo_full && !pop) overflow <= 1'b1;
            done <= !downloading && !hold_valid && fifo_empty && !sdram_req;
        end
    end

endmodule

// File: tb/tb_jtpopeye_prog_sink.sv
// Directed bench for jtpopeye_prog_sink: merging, timeout, PROM filter, end flush,
// back-pressure with overflow, overlapping lanes and mid-transfer reset.
module tb_jtpopeye_prog_sink;

    localparam int DEPTH    = 4;
    localparam int HOLD_CYC = 15;

    logic        clk_rom = 1'b0;
    logic        rst;
    logic        downloading;
    logic        prog_we;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic [15:0] sdram_din;
    logic [1:0]  sdram_mask;
    logic        sdram_ack;
    logic        done;
    logic        overflow;

    int n_compared   = 0;
    int n_mismatched = 0;

    jtpopeye_prog_sink #(
        .DEPTH    (DEPTH),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .clk_rom     (clk_rom),
        .rst         (rst),
        .downloading (downloading),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_din   (sdram_din),
        .sdram_mask  (sdram_mask),
        .sdram_ack   (sdram_ack),
        .done        (done),
        .overflow    (overflow)
    );

    always #5 clk_rom = ~clk_rom;

    task automatic step();
        @(posedge clk_rom);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [39:0] observed, input logic [39:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [21:0] addr, input logic [7:0] data, input logic [1:0] mask);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        prog_mask = mask;
        step();
        prog_we   = 1'b0;
    endtask

    task automatic ackOnce();
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
    endtask

    task automatic waitReq(input string tag, output int cycles);
        cycles = 0;
        while (sdram_req !== 1'b1 && cycles < 60) begin
            step();
            cycles++;
        end
        checkOutput({tag, "_req"}, 40'(sdram_req), 40'd1);
    endtask

    task automatic checkWord(input string tag, input logic [21:0] addr, input logic [15:0] din, input logic [1:0] mask);
        checkOutput({tag, "_addr"}, 40'(sdram_addr), 40'(addr));
        checkOutput({tag, "_din"},  40'(sdram_din),  40'(din));
        checkOutput({tag, "_mask"}, 40'(sdram_mask), 40'(mask));
    endtask

    initial begin
        int          cyc;
        logic        saw_req;
        logic [15:0] bp_din  [5];
        logic [21:0] bp_addr [5];

        rst = 1'b1; downloading = 1'b0; prog_we = 1'b0; prog_addr = '0;
        prog_data = '0; prog_mask = 2'b11; sdram_ack = 1'b0;
        step(); step();
        checkOutput("rst_req", 40'(sdram_req), 40'd0);
        checkOutput("rst_addr", 40'(sdram_addr), 40'd0);
        checkOutput("rst_din", 40'(sdram_din), 40'd0);
        checkOutput("rst_mask", 40'(sdram_mask), 40'h3);
        checkOutput("rst_done", 40'(done), 40'd0);
        checkOutput("rst_ovf", 40'(overflow), 40'd0);
        rst = 1'b0;
        step();
        checkOutput("idle_done", 40'(done), 40'd1);

        // Byte pair merge into one word
        downloading = 1'b1;
        step();
        checkOutput("dl_done_clr", 40'(done), 40'd0);
        applyStimulus(22'h10, 8'hAA, 2'b01);
        applyStimulus(22'h10, 8'h55, 2'b10);
        checkOutput("merge_lat_req", 40'(sdram_req), 40'd0);
        step();
        checkOutput("merge_req", 40'(sdram_req), 40'd1);
        checkWord("merge", 22'h10, 16'hAA55, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("merge_hold_req", 40'(sdram_req), 40'd1);
            checkOutput("merge_hold_din", 40'(sdram_din), 40'hAA55);
        end
        ackOnce();
        checkOutput("merge_ack_req", 40'(sdram_req), 40'd0);
        saw_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            saw_req = saw_req | sdram_req;
        end
        checkOutput("merge_single", 40'(saw_req), 40'd0);

        // Lone byte held until timeout
        applyStimulus(22'h20, 8'h7E, 2'b10);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (sdram_req !== 1'b1 && cyc < 60);
        checkOutput("timeout_latency", 40'(cyc), 40'(HOLD_CYC + 1));
        checkWord("timeout", 22'h20, 16'h7E7E, 2'b10);
        ackOnce();
        checkOutput("timeout_ack_req", 40'(sdram_req), 40'd0);

        // Overlapping lane forces two separate words
        applyStimulus(22'h30, 8'h11, 2'b01);
        applyStimulus(22'h30, 8'h22, 2'b01);
        step();
        checkOutput("overlap1_req", 40'(sdram_req), 40'd1);
        checkWord("overlap1", 22'h30, 16'h1111, 2'b01);
        ackOnce();
        checkOutput("overlap1_ack_req", 40'(sdram_req), 40'd0);
        waitReq("overlap2", cyc);
        checkWord("overlap2", 22'h30, 16'h2222, 2'b01);
        ackOnce();

        // PROM traffic ignored, then end-of-download flush
        applyStimulus(22'h40, 8'h99, 2'b11);
        applyStimulus(22'h41, 8'h98, 2'b11);
        saw_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            saw_req = saw_req | sdram_req;
        end
        checkOutput("prom_no_req", 40'(saw_req), 40'd0);
        applyStimulus(22'h50, 8'h3C, 2'b01);
        downloading = 1'b0;
        step();
        checkOutput("flush_req_early", 40'(sdram_req), 40'd0);
        checkOutput("flush_done_early", 40'(done), 40'd0);
        step();
        checkOutput("flush_req", 40'(sdram_req), 40'd1);
        checkWord("flush", 22'h50, 16'h3C3C, 2'b01);
        step();
        checkOutput("flush_done_wait", 40'(done), 40'd0);
        ackOnce();
        checkOutput("flush_ack_req", 40'(sdram_req), 40'd0);
        checkOutput("flush_done_ack", 40'(done), 40'd0);
        step();
        checkOutput("flush_done", 40'(done), 40'd1);

        // Back-pressure: six full words, ack withheld; the fifth is dropped
        downloading = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(22'h100 + 22'(k), 8'(k + 1), 2'b00);
            if (k == 4) checkOutput("bp_full_no_ovf", 40'(overflow), 40'd0);
        end
        checkOutput("bp_ovf", 40'(overflow), 40'd1);
        bp_addr[0] = 22'h100; bp_din[0] = 16'h0101;
        bp_addr[1] = 22'h101; bp_din[1] = 16'h0202;
        bp_addr[2] = 22'h102; bp_din[2] = 16'h0303;
        bp_addr[3] = 22'h103; bp_din[3] = 16'h0404;
        bp_addr[4] = 22'h105; bp_din[4] = 16'h0606;
        for (int k = 0; k < 5; k++) begin
            waitReq($sformatf("bp%0d", k), cyc);
            checkWord($sformatf("bp%0d", k), bp_addr[k], bp_din[k], 2'b00);
            ackOnce();
        end
        checkOutput("bp_drain_req", 40'(sdram_req), 40'd0);
        saw_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            saw_req = saw_req | sdram_req;
        end
        checkOutput("bp_no_extra", 40'(saw_req), 40'd0);
        checkOutput("bp_ovf_sticky", 40'(overflow), 40'd1);

        // Reset while a request is pending with two entries queued
        applyStimulus(22'h200, 8'hA1, 2'b00);
        applyStimulus(22'h201, 8'hA2, 2'b00);
        applyStimulus(22'h202, 8'hA3, 2'b00);
        checkOutput("mid_req", 40'(sdram_req), 40'd1);
        checkWord("mid", 22'h200, 16'hA1A1, 2'b00);
        rst = 1'b1;
        sdram_ack = 1'b1;
        #2;
        checkOutput("mid_rst_req", 40'(sdram_req), 40'd0);
        checkOutput("mid_rst_addr", 40'(sdram_addr), 40'd0);
        checkOutput("mid_rst_din", 40'(sdram_din), 40'd0);
        checkOutput("mid_rst_mask", 40'(sdram_mask), 40'h3);
        checkOutput("mid_rst_ovf", 40'(overflow), 40'd0);
        step(); step();
        rst = 1'b0;
        sdram_ack = 1'b0;
        saw_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            saw_req = saw_req | sdram_req;
        end
        checkOutput("mid_no_req", 40'(saw_req), 40'd0);
        downloading = 1'b0;
        step(); step();
        checkOutput("end_done", 40'(done), 40'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
